// File: rtl/lc3_pc_pkg.sv
// Shared definitions for the LC-3 program-counter unit and its return-address stack.
// The pcmux encodings are also used by the control FSM that drives this block.
package lc3_pc_pkg;

  localparam logic [2:0] PCMUX_INC  = 3'b000;
  localparam logic [2:0] PCMUX_BUS  = 3'b001;
  localparam logic [2:0] PCMUX_ADDR = 3'b010;
  localparam logic [2:0] PCMUX_VEC  = 3'b011;
  localparam logic [2:0] PCMUX_POP  = 3'b100;

  // One operation per cycle on the stack storage; flush dominates everything else.
  typedef enum logic [2:0] {
    RAS_IDLE,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP,
    RAS_FLUSH
  } ras_op_e;

endpackage

// File: rtl/lc3_ras.sv
// Circular return-address stack. A full stack overwrites its oldest entry, and a
// pop from an empty stack only raises the sticky underflow flag.
module lc3_ras
  import lc3_pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;        // next free slot; the top lives at ptr-1
  logic [CW-1:0]    cnt;
  logic             ovf_q;
  logic             unf_q;

  ras_op_e          op;
  logic             unf_evt;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign top   = mem[ptr - PW'(1)];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op      = RAS_IDLE;
    unf_evt = 1'b0;
    if (flush) begin
      op = RAS_FLUSH;
    end else begin
      unf_evt = pop && empty;
      if (push && pop && !empty) begin
        op = RAS_SWAP;
      end else if (push) begin
        op = RAS_PUSH;
      end else if (pop && !empty) begin
        op = RAS_POP;
      end
    end
  end

  // A swap rewrites the current top in place; a push fills the next free slot.
  assign wr_en   = (op == RAS_PUSH) || (op == RAS_SWAP);
  assign wr_addr = (op == RAS_SWAP) ? (ptr - PW'(1)) : ptr;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (op)
        RAS_FLUSH: begin
          cnt   <= '0;
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
        end
        RAS_PUSH: begin
          ptr <= ptr + PW'(1);
          if (full) begin
            ovf_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RAS_POP: begin
          ptr <= ptr - PW'(1);
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
      if (unf_evt) begin
        unf_q <= 1'b1;
      end
    end
  end

  // NOTE: the entry storage has no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= push_data;
    end
  end

endmodule

// File: rtl/lc3_pc_ras.sv
// LC-3 program counter with next-PC selection and a hardware return-address stack
// that predicts RET targets pushed by JSR/JSRR.
module lc3_pc_ras
  import lc3_pc_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_pc,
  input  logic [2:0]                   pcmux,
  input  logic                         push,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             addr_out,
  input  logic [WIDTH-1:0]             data_bus,
  input  logic [7:0]                   vec,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_inc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;

  assign pc_inc   = pc + WIDTH'(1);
  assign ras_push = ld_pc && push;
  assign ras_pop  = ld_pc && (pcmux == PCMUX_POP);

  lc3_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .flush     (flush),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  always_comb begin
    pc_nxt = pc_inc;
    case (pcmux)
      PCMUX_BUS:  pc_nxt = data_bus;
      PCMUX_ADDR: pc_nxt = addr_out;
      PCMUX_VEC:  pc_nxt = {{(WIDTH-8){1'b0}}, vec};
      // An empty stack falls back to the software-supplied target, unless a
      // flush in the same cycle forces the stored top to be taken.
      PCMUX_POP:  pc_nxt = (ras_empty && !flush) ? data_bus : ras_top;
      default:    pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (ld_pc) begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_lc3_pc_ras.sv
// Directed and randomized bench for lc3_pc_ras, checked against a queue-based
// return-stack model kept in the bench.
module tb_lc3_pc_ras;

  localparam int W = 16;
  localparam int D = 8;
  localparam logic [15:0] RST_PC = 16'h0000;

  localparam logic [2:0] M_INC = 3'd0, M_BUS = 3'd1, M_ADDR = 3'd2, M_VEC = 3'd3, M_POP = 3'd4;

  logic        clk;
  logic        rst;
  logic        ld_pc;
  logic [2:0]  pcmux;
  logic        push;
  logic        flush;
  logic [15:0] addr_out;
  logic [15:0] data_bus;
  logic [7:0]  vec;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [3:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the stack is a queue whose back is the top entry.
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_ovf;
  logic        m_unf;

  lc3_pc_ras #(
    .WIDTH     (W),
    .RAS_DEPTH (D),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_pc     (ld_pc),
    .pcmux     (pcmux),
    .push      (push),
    .flush     (flush),
    .addr_out  (addr_out),
    .data_bus  (data_bus),
    .vec       (vec),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, and settle just after the edge.
  task automatic cycle(input logic r, input logic ld, input logic [2:0] mux,
                       input logic ps, input logic fl,
                       input logic [15:0] ad, input logic [15:0] bs, input logic [7:0] v);
    logic [15:0] nxt;
    logic [15:0] inc;
    rst = r; ld_pc = ld; pcmux = mux; push = ps; flush = fl;
    addr_out = ad; data_bus = bs; vec = v;
    inc = m_pc + 16'd1;
    if (!r) begin
      m_pc = RST_PC;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      nxt = m_pc;
      if (ld) begin
        case (mux)
          M_BUS:   nxt = bs;
          M_ADDR:  nxt = ad;
          M_VEC:   nxt = {8'h00, v};
          M_POP:   nxt = (m_stk.size() > 0) ? m_stk[$] : bs;
          default: nxt = inc;
        endcase
      end
      if (fl) begin
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else if (ld) begin
        if (mux == M_POP && ps && m_stk.size() > 0) begin
          m_stk[m_stk.size()-1] = inc;
        end else begin
          if (mux == M_POP) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_unf = 1'b1;
          end
          if (ps) begin
            m_stk.push_back(inc);
            if (m_stk.size() > D) begin
              void'(m_stk.pop_front());
              m_ovf = 1'b1;
            end
          end
        end
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, M_INC, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_vec++; if (ras_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", ras_count); end
    n_vec++; if ({ras_ovf, ras_unf, ras_empty, ras_full} !== 4'b0010) begin
      n_err++; $display("FAIL reset_flags: got ovf/unf/empty/full %b want 0010", {ras_ovf, ras_unf, ras_empty, ras_full});
    end
    cycle(1'b1, 1'b1, M_BUS, 1'b0, 1'b0, 16'h0, 16'hFFFE, 8'h0);
    cycle(1'b1, 1'b1, M_INC, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL inc_ffff: got %h want ffff", pc); end
    n_vec++; if (pc_inc !== 16'h0000) begin n_err++; $display("FAIL pc_inc_wrap: got %h want 0000", pc_inc); end
    cycle(1'b1, 1'b1, M_INC, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL inc_wrap: got %h want 0000", pc); end
    cycle(1'b1, 1'b1, M_INC, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h0001) begin n_err++; $display("FAIL inc_0001: got %h want 0001", pc); end
  endtask

  task automatic test_call_return();
    cycle(1'b1, 1'b1, M_BUS, 1'b0, 1'b0, 16'h0, 16'h3000, 8'h0);
    cycle(1'b1, 1'b1, M_ADDR, 1'b1, 1'b0, 16'h4000, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h4000 || ras_count !== 4'd1) begin
      n_err++; $display("FAIL call: got pc %h count %0d want 4000 1", pc, ras_count);
    end
    cycle(1'b1, 1'b1, M_POP, 1'b0, 1'b0, 16'h0, 16'hDEAD, 8'h0);
    n_vec++; if (pc !== 16'h3001 || ras_count !== 4'd0) begin
      n_err++; $display("FAIL return: got pc %h count %0d want 3001 0", pc, ras_count);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b1, M_BUS, 1'b0, 1'b0, 16'h0, 16'h0100, 8'h0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (ras_count !== 4'd8 || ras_ovf !== 1'b1 || ras_full !== 1'b1) begin
      n_err++; $display("FAIL overflow: got count %0d ovf %b full %b want 8 1 1", ras_count, ras_ovf, ras_full);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, M_POP, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
      n_vec++; if (pc !== 16'h0109 - 16'(i) || ras_count !== 4'(7 - i)) begin
        n_err++; $display("FAIL ovf_pop%0d: got pc %h count %0d want %h %0d", i, pc, ras_count, 16'h0109 - 16'(i), 7 - i);
      end
    end
    cycle(1'b1, 1'b1, M_POP, 1'b0, 1'b0, 16'h0, 16'hBEEF, 8'h0);
    n_vec++; if (pc !== 16'hBEEF || ras_unf !== 1'b1 || ras_count !== 4'd0) begin
      n_err++; $display("FAIL underflow: got pc %h unf %b count %0d want beef 1 0", pc, ras_unf, ras_count);
    end
  endtask

  task automatic test_pop_push();
    cycle(1'b1, 1'b0, M_INC, 1'b0, 1'b1, 16'h0, 16'h0, 8'h0);
    n_vec++; if ({ras_ovf, ras_unf} !== 2'b00 || ras_count !== 4'd0) begin
      n_err++; $display("FAIL flush_clear: got ovf/unf %b count %0d want 00 0", {ras_ovf, ras_unf}, ras_count);
    end
    cycle(1'b1, 1'b1, M_BUS, 1'b0, 1'b0, 16'h0, 16'h2221, 8'h0);
    cycle(1'b1, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    cycle(1'b1, 1'b1, M_BUS, 1'b0, 1'b0, 16'h0, 16'h5000, 8'h0);
    cycle(1'b1, 1'b1, M_POP, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h2222 || ras_count !== 4'd1 || {ras_ovf, ras_unf} !== 2'b00) begin
      n_err++; $display("FAIL swap: got pc %h count %0d flags %b want 2222 1 00", pc, ras_count, {ras_ovf, ras_unf});
    end
    cycle(1'b1, 1'b1, M_POP, 1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h5001 || ras_count !== 4'd0) begin
      n_err++; $display("FAIL swap_top: got pc %h count %0d want 5001 0", pc, ras_count);
    end
  endtask

  task automatic test_hold_flush();
    cycle(1'b1, 1'b1, M_POP, 1'b0, 1'b0, 16'h0, 16'h7777, 8'h0);
    cycle(1'b1, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    cycle(1'b1, 1'b0, M_POP, 1'b1, 1'b0, 16'h0, 16'h1234, 8'h0);
    n_vec++; if (pc !== 16'h7778 || ras_count !== 4'd1 || ras_unf !== 1'b1) begin
      n_err++; $display("FAIL hold: got pc %h count %0d unf %b want 7778 1 1", pc, ras_count, ras_unf);
    end
    cycle(1'b1, 1'b0, M_INC, 1'b0, 1'b1, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h7778 || ras_count !== 4'd0 || ras_unf !== 1'b0 || ras_empty !== 1'b1) begin
      n_err++; $display("FAIL flush_idle: got pc %h count %0d unf %b empty %b want 7778 0 0 1", pc, ras_count, ras_unf, ras_empty);
    end
    // Flush beats a simultaneous pop+push: top is taken, push discarded.
    cycle(1'b1, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    cycle(1'b1, 1'b1, M_BUS, 1'b1, 1'b0, 16'h0, 16'h6000, 8'h0);
    cycle(1'b1, 1'b1, M_POP, 1'b1, 1'b1, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== 16'h777A || ras_count !== 4'd0 || {ras_ovf, ras_unf} !== 2'b00) begin
      n_err++; $display("FAIL flush_pop: got pc %h count %0d flags %b want 777a 0 00", pc, ras_count, {ras_ovf, ras_unf});
    end
  endtask

  task automatic test_vector_reset();
    cycle(1'b1, 1'b1, M_VEC, 1'b0, 1'b0, 16'h0, 16'h0, 8'h25);
    n_vec++; if (pc !== 16'h0025) begin n_err++; $display("FAIL vector: got %h want 0025", pc); end
    cycle(1'b1, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    cycle(1'b1, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    cycle(1'b0, 1'b1, M_INC, 1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    n_vec++; if (pc !== RST_PC || ras_count !== 4'd0 || {ras_ovf, ras_unf} !== 2'b00) begin
      n_err++; $display("FAIL mid_reset: got pc %h count %0d flags %b want %h 0 00", pc, ras_count, {ras_ovf, ras_unf}, RST_PC);
    end
  endtask

  task automatic test_random();
    logic r, ld, ps, fl;
    logic [2:0] mux;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) != 0);
      ld  = ($urandom_range(0, 3) != 0);
      mux = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) mux = M_POP;
      ps  = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      // Keep clear of pops on an empty stack combined with push or flush.
      if (ld && mux == M_POP && m_stk.size() == 0) begin
        ps = 1'b0;
        fl = 1'b0;
      end
      cycle(r, ld, mux, ps, fl, 16'($urandom), 16'($urandom), 8'($urandom));
      n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
      n_vec++; if (pc_inc !== m_pc + 16'd1) begin n_err++; $display("FAIL rnd_inc[%0d]: got %h want %h", i, pc_inc, m_pc + 16'd1); end
      n_vec++; if (ras_count !== 4'(m_stk.size())) begin
        n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, ras_count, m_stk.size());
      end
      n_vec++; if (ras_empty !== (m_stk.size() == 0) || ras_full !== (m_stk.size() == D)) begin
        n_err++; $display("FAIL rnd_ef[%0d]: got empty %b full %b want size %0d", i, ras_empty, ras_full, m_stk.size());
      end
      n_vec++; if ({ras_ovf, ras_unf} !== {m_ovf, m_unf}) begin
        n_err++; $display("FAIL rnd_flags[%0d]: got %b want %b", i, {ras_ovf, ras_unf}, {m_ovf, m_unf});
      end
    end
  endtask

  initial begin
    rst = 1'b0; ld_pc = 1'b0; pcmux = M_INC; push = 1'b0; flush = 1'b0;
    addr_out = '0; data_bus = '0; vec = '0;
    m_pc = RST_PC; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_call_return();
    test_overflow();
    test_pop_push();
    test_hold_flush();
    test_vector_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
